// File: rtl/ets_pkg.sv
// Shared definitions for the equivalent-time-sampling accumulator core:
// FSM state encoding and the address-width helper used to size counters and ports.
package ets_pkg;

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_ARM     = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } ets_state_e;

  // Width of an index into n entries; never below one bit so ports stay legal.
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ets_acc_bank.sv
// Accumulator word storage: one saturating read-modify-write port and one
// registered read port whose output resets to zero.
module ets_acc_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int AW         = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic                  i_clr,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [ACC_WIDTH-1:0]  o_rd_data,
  output logic                  o_sat
);

  localparam int DEPTH = 1 << AW;

  logic [ACC_WIDTH-1:0] r_mem [DEPTH];
  logic [ACC_WIDTH-1:0] r_rd_data;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_carry;

  // One extra bit catches the carry that signals saturation.
  assign w_sum   = {1'b0, r_mem[i_wr_addr]} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, i_din};
  assign w_carry = w_sum[ACC_WIDTH];
  assign o_sat   = i_wr_en & ~i_clr & w_carry;

  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      if (i_clr) begin
        r_mem[i_wr_addr] <= '0;
      end else if (w_carry) begin
        r_mem[i_wr_addr] <= '1;
      end else begin
        r_mem[i_wr_addr] <= w_sum[ACC_WIDTH-1:0];
      end
    end
  end

  // A read that collides with a write returns the pre-write value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ets_accum_core.sv
// Equivalent-time-sampling averaging core: after a trigger edge, each capture
// cycle adds one registered ADC sample into word [phase][bin], repeated num_avg passes.
module ets_accum_core
  import ets_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PHASES = 2,
  parameter int NUM_BINS   = 8,
  parameter int ACC_WIDTH  = 32,
  localparam int PW = addr_width(NUM_PHASES),
  localparam int BW = addr_width(NUM_BINS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sync,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  trig,
  input  logic [31:0]           num_avg,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic [PW-1:0]         rd_phase,
  input  logic [BW-1:0]         rd_bin,
  output logic [ACC_WIDTH-1:0]  rd_data,
  output logic [31:0]           passes_left,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  signal_generate_en,
  output ets_state_e            dbg_state
);

  ets_state_e            r_state;
  ets_state_e            w_next;
  logic [PW-1:0]         r_phase;
  logic [BW-1:0]         r_bin;
  logic [DATA_WIDTH-1:0] r_adc;
  logic                  r_trig_d;
  logic [31:0]           r_passes;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovf;
  logic                  r_sge;
  logic                  w_last;
  logic                  w_trig_edge;
  logic                  w_abort;
  logic                  w_advance;
  logic                  w_sat;

  assign w_last      = (r_phase == PW'(NUM_PHASES - 1)) && (r_bin == BW'(NUM_BINS - 1));
  assign w_trig_edge = trig & ~r_trig_d;
  assign w_abort     = abort && (r_state inside {ST_CLEAR, ST_ARM, ST_CAPTURE});
  // The word walk is shared by CLEAR and CAPTURE; an abort freezes storage.
  assign w_advance   = (r_state inside {ST_CLEAR, ST_CAPTURE}) && !w_abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_adc    <= '0;
      r_trig_d <= 1'b0;
    end else begin
      r_adc    <= adc_data;
      r_trig_d <= trig;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_SYNC:    if (sync) w_next = ST_IDLE;
      ST_IDLE:    if (start) w_next = ST_CLEAR;
      ST_CLEAR: begin
        if (w_abort)     w_next = ST_IDLE;
        else if (w_last) w_next = (r_passes == 32'd0) ? ST_DONE : ST_ARM;
      end
      ST_ARM: begin
        if (w_abort)          w_next = ST_IDLE;
        else if (w_trig_edge) w_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (w_abort)     w_next = ST_IDLE;
        else if (w_last) w_next = (r_passes <= 32'd1) ? ST_DONE : ST_ARM;
      end
      ST_DONE:    if (!start) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_SYNC;
      r_phase  <= '0;
      r_bin    <= '0;
      r_passes <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_sge    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next inside {ST_CLEAR, ST_ARM, ST_CAPTURE});
      r_sge   <= (w_next inside {ST_ARM, ST_CAPTURE});
      r_done  <= (w_next == ST_DONE);

      if (w_advance) begin
        r_phase <= r_phase + 1'b1;
        if (r_phase == PW'(NUM_PHASES - 1)) begin
          r_bin <= r_bin + 1'b1;
        end
      end else begin
        r_phase <= '0;
        r_bin   <= '0;
      end

      if (r_state == ST_IDLE && start) begin
        r_passes <= num_avg;
      end else if (r_state == ST_CAPTURE && w_last && !w_abort) begin
        r_passes <= r_passes - 32'd1;
      end

      // Overflow is sticky for the whole run and drops when the next run clears.
      if (r_state == ST_IDLE && start) begin
        r_ovf <= 1'b0;
      end else if (w_sat) begin
        r_ovf <= 1'b1;
      end
    end
  end

  ets_acc_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .AW         (PW + BW)
  ) u_bank (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (w_advance),
    .i_clr     (r_state == ST_CLEAR),
    .i_wr_addr ({r_bin, r_phase}),
    .i_din     (r_adc),
    .i_rd_addr ({rd_bin, rd_phase}),
    .o_rd_data (rd_data),
    .o_sat     (w_sat)
  );

  assign passes_left        = r_passes;
  assign busy               = r_busy;
  assign done               = r_done;
  assign overflow           = r_ovf;
  assign signal_generate_en = r_sge;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_ets_accum_core.sv
// Bench for ets_accum_core: a default-width core and a 9-bit-accumulator core
// share one stimulus stream and are checked every cycle against a pass-level model.
module tb_ets_accum_core;
  import ets_pkg::*;

  localparam int NP = 2;
  localparam int NB = 8;
  localparam int NW = NP * NB;
  localparam int MAX9 = 511;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sync = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        trig = 1'b0;
  logic [31:0] num_avg = '0;
  logic [7:0]  adc_data = '0;
  logic [0:0]  rd_phase = '0;
  logic [2:0]  rd_bin = '0;

  logic [31:0] rd_data32, pl32;
  logic        busy32, done32, ovf32, sge32;
  ets_state_e  st32;
  logic [8:0]  rd_data9;
  logic [31:0] pl9;
  logic        busy9, done9, ovf9, sge9;
  ets_state_e  st9;

  ets_state_e  exp_st = ST_SYNC;
  logic [31:0] exp_pl = '0;
  logic        exp_ovf32 = 1'b0;
  logic        exp_ovf9 = 1'b0;
  logic        exp_rd_valid = 1'b0;
  logic [31:0] exp_q32[$];
  logic [8:0]  exp_q9[$];
  longint      mdl32[NW];
  int          mdl9[NW];
  int          n_assert = 0;
  int          n_fail = 0;

  ets_accum_core u_dut (
    .clock(clock), .reset(reset), .sync(sync), .start(start), .abort(abort),
    .trig(trig), .num_avg(num_avg), .adc_data(adc_data), .rd_phase(rd_phase),
    .rd_bin(rd_bin), .rd_data(rd_data32), .passes_left(pl32), .busy(busy32),
    .done(done32), .overflow(ovf32), .signal_generate_en(sge32), .dbg_state(st32)
  );

  ets_accum_core #(.ACC_WIDTH(9)) u_sat (
    .clock(clock), .reset(reset), .sync(sync), .start(start), .abort(abort),
    .trig(trig), .num_avg(num_avg), .adc_data(adc_data), .rd_phase(rd_phase),
    .rd_bin(rd_bin), .rd_data(rd_data9), .passes_left(pl9), .busy(busy9),
    .done(done9), .overflow(ovf9), .signal_generate_en(sge9), .dbg_state(st9)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Outputs are compared 1 time unit after each rising edge against the
  // expectation the driver posted for that edge.
  initial begin
    logic eb, es, ed;
    forever begin
      @(posedge clock);
      #1;
      eb = exp_st inside {ST_CLEAR, ST_ARM, ST_CAPTURE};
      es = exp_st inside {ST_ARM, ST_CAPTURE};
      ed = (exp_st == ST_DONE);
      chk("state",    64'(st32),  64'(exp_st));
      chk("busy",     64'(busy32), 64'(eb));
      chk("sig_gen",  64'(sge32),  64'(es));
      chk("done",     64'(done32), 64'(ed));
      chk("passes",   64'(pl32),   64'(exp_pl));
      chk("ovf32",    64'(ovf32),  64'(exp_ovf32));
      chk("state9",   64'(st9),    64'(exp_st));
      chk("passes9",  64'(pl9),    64'(exp_pl));
      chk("busy9",    64'({done9, sge9, busy9}), 64'({ed, es, eb}));
      chk("ovf9",     64'(ovf9),   64'(exp_ovf9));
      if (exp_rd_valid) begin
        if (exp_q32.size() == 0 || exp_q9.size() == 0) begin
          chk("rd_queue", 64'(0), 64'(1));
        end else begin
          chk("rd_data32", 64'(rd_data32), 64'(exp_q32.pop_front()));
          chk("rd_data9",  64'(rd_data9),  64'(exp_q9.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_assert);
    $fatal(1, "watchdog");
  end

  // ---------------- model and drivers ----------------
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic add_word(input int idx, input int v);
    mdl32[idx] = mdl32[idx] + v;
    if (mdl9[idx] + v > MAX9) begin
      mdl9[idx] = MAX9;
      exp_ovf9  = 1'b1;
    end else begin
      mdl9[idx] = mdl9[idx] + v;
    end
  endtask

  task automatic push_read(input int idx);
    exp_q32.push_back(mdl32[idx][31:0]);
    exp_q9.push_back(9'(mdl9[idx]));
    exp_rd_valid = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; sync = 1'b0; start = 1'b0; trig = 1'b0; abort = 1'b0;
    exp_st = ST_SYNC; exp_pl = '0; exp_ovf32 = 1'b0; exp_ovf9 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q32.push_back('0);
      exp_q9.push_back('0);
      exp_rd_valid = 1'b1;
      cyc();
    end
    reset = 1'b0;
    exp_rd_valid = 1'b0;
    cyc();
  endtask

  task automatic do_sync();
    start = 1'b1; exp_st = ST_SYNC; cyc();
    start = 1'b0; sync = 1'b1; exp_st = ST_IDLE; cyc();
    sync = 1'b0; cyc();
  endtask

  task automatic begin_run(input int n);
    num_avg = n; start = 1'b1;
    exp_pl = n; exp_ovf32 = 1'b0; exp_ovf9 = 1'b0; exp_st = ST_CLEAR;
    cyc();
    num_avg = 32'hFF;
    for (int i = 0; i < NW - 1; i++) cyc();
    for (int i = 0; i < NW; i++) begin
      mdl32[i] = 0;
      mdl9[i]  = 0;
    end
    exp_st = (n == 0) ? ST_DONE : ST_ARM;
    cyc();
  endtask

  task automatic arm_wait(input int hold_cycles, input int low_cycles);
    exp_st = ST_ARM;
    trig = 1'b1;
    for (int i = 0; i < hold_cycles; i++) cyc();
    trig = 1'b0;
    for (int i = 0; i < low_cycles; i++) cyc();
  endtask

  // One pass; word k receives the sample presented on the trigger edge plus k cycles.
  // Word 0 is read back every cycle to see in-progress sums.
  task automatic capture_pass(input int base, input bit ramp, input bit hold_after,
                              input int cut_k, input bit cut_reset);
    int s[NW];
    for (int k = 0; k < NW; k++) s[k] = ramp ? k : base;
    for (int k = 0; k <= NW; k++) begin
      if (k == cut_k) begin
        exp_rd_valid = 1'b0;
        if (cut_reset) begin
          do_reset();
        end else begin
          abort = 1'b1; start = 1'b0; exp_st = ST_IDLE;
          cyc();
          abort = 1'b0;
          cyc();
        end
        return;
      end
      trig = (k == 0) ? 1'b1 : ((k == NW) ? hold_after : (k % 3 == 1));
      if (k < NW) adc_data = 8'(s[k]);
      rd_phase = '0; rd_bin = '0;
      push_read(0);
      if (k >= 1) add_word(k - 1, s[k-1]);
      if (k == NW) begin
        exp_pl = exp_pl - 1;
        exp_st = (exp_pl == 0) ? ST_DONE : ST_ARM;
      end else begin
        exp_st = ST_CAPTURE;
      end
      cyc();
    end
    exp_rd_valid = 1'b0;
  endtask

  task automatic finish_run();
    start = 1'b1; exp_st = ST_DONE; cyc();
    start = 1'b0; exp_st = ST_IDLE; cyc();
  endtask

  task automatic read_all();
    for (int a = 0; a < NW; a++) begin
      rd_phase = 1'(a % NP);
      rd_bin   = 3'(a / NP);
      push_read(a);
      cyc();
    end
    exp_rd_valid = 1'b0;
  endtask

  task automatic full_run(input int n, input int base, input bit ramp, input bit hold);
    begin_run(n);
    for (int p = 0; p < n; p++) begin
      arm_wait((hold && p == 1) ? 3 : 0, 1);
      capture_pass(base, ramp, hold && p == 0 && n > 1, -1, 1'b0);
    end
    finish_run();
    read_all();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    @(negedge clock);
    do_reset();
    do_sync();

    // constant 5, single pass
    full_run(1, 5, 1'b0, 1'b0);
    chk("pin_const_w0", mdl32[0], 5);
    chk("pin_const_w15", mdl32[15], 5);

    // ramp, three passes, trig held high into ARM and toggled in CAPTURE
    full_run(3, 0, 1'b1, 1'b1);
    chk("pin_ramp_p1b3", mdl32[7], 21);
    chk("pin_ramp_p1b7", mdl32[15], 45);
    chk("pin_ramp_p0b0", mdl32[0], 0);

    // full-scale samples saturate the 9-bit core only
    full_run(4, 255, 1'b0, 1'b0);
    chk("pin_sat9", mdl9[0], 511);
    chk("pin_sat32", mdl32[0], 1020);
    chk("pin_ovf9", exp_ovf9, 1);

    // zero passes: CLEAR straight to DONE, words zeroed, overflow cleared
    full_run(0, 0, 1'b0, 1'b0);
    chk("pin_zero_w3", mdl32[3], 0);

    // abort in the second of four passes
    begin_run(4);
    arm_wait(0, 1);
    capture_pass(7, 1'b0, 1'b0, -1, 1'b0);
    arm_wait(0, 1);
    capture_pass(7, 1'b0, 1'b0, 5, 1'b0);
    read_all();
    chk("pin_abort_pl", exp_pl, 3);
    chk("pin_abort_w3", mdl32[3], 14);
    chk("pin_abort_w4", mdl32[4], 7);

    // reset in CAPTURE, then a fresh sync/start run
    begin_run(2);
    arm_wait(0, 1);
    capture_pass(3, 1'b0, 1'b0, 8, 1'b1);
    do_sync();
    full_run(1, 9, 1'b0, 1'b0);
    chk("pin_after_reset", mdl32[15], 9);

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
